// File: rtl/instruction_fetch_queue.sv
// Fetch stage with a DEPTH-entry prefetch FIFO of {instruction, PC} pairs, drained by decode over valid/ready.
// Define IFQ_BYPASS_EN to present a response arriving into an empty FIFO combinationally on out_*.
module instruction_fetch_queue #(
    parameter int unsigned       ADDR_W   = 64,
    parameter int unsigned       INSTR_W  = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       PC_STEP  = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     redirect,
    input  logic [ADDR_W-1:0]        redirect_pc,
    output logic                     imem_en,
    output logic [ADDR_W-1:0]        imem_addr,
    input  logic [INSTR_W-1:0]       imem_rdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INSTR_W-1:0]       out_instr,
    output logic [ADDR_W-1:0]        out_pc,
    output logic [ADDR_W-1:0]        out_pc_link,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] STEP_C  = ADDR_W'(PC_STEP);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } entry_t;

    state_t             state_q;
    logic [ADDR_W-1:0]  fpc_q;
    logic               infl_q;
    logic [ADDR_W-1:0]  infl_pc_q;
    entry_t             fifo_mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [CNT_W-1:0]   count_q;
    entry_t             hold_q;
    logic [ADDR_W-1:0]  hold_link_q;

    logic               credit;
    logic               issue;
    logic               fifo_has;
    logic               bypass;
    logic               pop;
    logic               fifo_pop;
    logic               push;
    entry_t             cur;

    // Credit counts the word in flight but not a same-cycle pop, so the FIFO can never overflow.
    assign credit    = (count_q + CNT_W'(infl_q)) < DEPTH_C;
    assign issue     = (state_q == RUN) && credit && !redirect;
    assign imem_en   = issue;
    assign imem_addr = fpc_q;
    assign occupancy = count_q;

    // NOTE: every signal assigned in always_comb gets a default first so no path can infer a latch.
    always_comb begin
        fifo_has = (count_q != '0);
        bypass   = 1'b0;
`ifdef IFQ_BYPASS_EN
        bypass   = infl_q && !fifo_has;
`endif
        out_valid = fifo_has || bypass;
        cur       = hold_q;
        if (fifo_has) begin
            cur = fifo_mem[rd_ptr_q];
        end else if (bypass) begin
            cur = '{instr: imem_rdata, pc: infl_pc_q};
        end
        out_instr   = cur.instr;
        out_pc      = cur.pc;
        out_pc_link = out_valid ? (cur.pc + STEP_C) : hold_link_q;
        // A redirect discards any pop in the same cycle and drops the arriving response.
        pop      = out_valid && out_ready && !redirect;
        fifo_pop = pop && fifo_has;
        push     = infl_q && !redirect && !(bypass && pop);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= BOOT;
            fpc_q     <= RESET_PC;
            infl_q    <= 1'b0;
            infl_pc_q <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            unique case (state_q)
                BOOT:    state_q <= RUN;
                RUN:     state_q <= credit ? RUN : HOLD;
                HOLD:    state_q <= credit ? RUN : HOLD;
                default: state_q <= BOOT;
            endcase
            if (redirect && state_q != BOOT) begin
                state_q <= RUN;
            end

            if (redirect) begin
                fpc_q <= {redirect_pc[ADDR_W-1:2], 2'b00};
            end else if (issue) begin
                fpc_q <= fpc_q + STEP_C;
            end

            infl_q <= issue;
            if (issue) begin
                infl_pc_q <= fpc_q;
            end

            if (redirect) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                end
                if (fifo_pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
                unique case ({push, fifo_pop})
                    2'b10:   count_q <= count_q + CNT_W'(1);
                    2'b01:   count_q <= count_q - CNT_W'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // NOTE: the FIFO storage is not reset; count_q gates every read, so stale contents are never visible.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= '{instr: imem_rdata, pc: infl_pc_q};
        end
    end

    // Last presented head, shown while the FIFO is empty.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_q      <= '0;
            hold_link_q <= '0;
        end else if (out_valid) begin
            hold_q      <= cur;
            hold_link_q <= out_pc_link;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Scoreboard bench for instruction_fetch_queue: directed scenarios followed by randomized ready/redirect traffic.
module tb_instruction_fetch_queue;

    localparam int unsigned ADDR_W   = 64;
    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'd0;
    localparam int unsigned PC_STEP  = 4;
`ifdef IFQ_BYPASS_EN
    localparam int FIRST_LAT = 2;
    localparam logic BYP     = 1'b1;
`else
    localparam int FIRST_LAT = 3;
    localparam logic BYP     = 1'b0;
`endif

    logic               clock;
    logic               reset;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               imem_en;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;
    logic [ADDR_W-1:0]  out_pc_link;
    logic [2:0]         occupancy;

    instruction_fetch_queue #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W),
        .DEPTH   (DEPTH),
        .RESET_PC(RESET_PC),
        .PC_STEP (PC_STEP)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_en    (imem_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .out_pc_link(out_pc_link),
        .occupancy  (occupancy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ {a[15:0], a[31:16]} ^ 32'h9E37_79B9;
    endfunction

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [63:0] link;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] fetch_exp;
    logic [63:0] last_pc;
    logic [31:0] last_instr;

    // Expected stream after a (re)start: sequential words from the aligned start address.
    task automatic model_restart(input logic [63:0] start);
        logic [63:0] p;
        exp_t e;
        exp_q.delete();
        p = start;
        for (int i = 0; i < 2048; i++) begin
            e.pc    = p;
            e.instr = mem_word(p);
            e.link  = p + 64'd4;
            exp_q.push_back(e);
            p = p + 64'd4;
        end
        fetch_exp = start;
    endtask

    task automatic set_redirect(input logic [63:0] target);
        redirect    = 1'b1;
        redirect_pc = target;
        model_restart(target & ~64'h3);
    endtask

    // Synchronous memory model: one-cycle read latency, garbage when not strobed.
    initial begin
        logic        en_s;
        logic [63:0] a_s;
        forever begin
            @(negedge clock);
            en_s = imem_en;
            a_s  = imem_addr;
            @(posedge clock);
            #1;
            imem_rdata = en_s ? mem_word(a_s) : 32'hBAD0_BAD0;
        end
    end

    // Monitor: compares every accepted head against the scoreboard and tracks the fetch stream.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset) begin
                last_pc    = 64'd0;
                last_instr = 32'd0;
            end else begin
                check("occupancy_bound", 64'(occupancy <= 3'(DEPTH)), 64'd1);
                if (redirect) begin
                    check("no_issue_on_redirect", 64'(imem_en), 64'd0);
                end
                if (imem_en) begin
                    check("fetch_addr", imem_addr, fetch_exp);
                    fetch_exp = fetch_exp + 64'd4;
                end
                if (out_valid) begin
                    if (out_ready && !redirect) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL sb_underflow actual_pc=0x%0h expected=none", out_pc);
                        end else begin
                            e = exp_q.pop_front();
                            check("out_pc", out_pc, e.pc);
                            check("out_instr", 64'(out_instr), 64'(e.instr));
                            check("out_pc_link", out_pc_link, e.link);
                        end
                    end
                    last_pc    = out_pc;
                    last_instr = out_instr;
                end else begin
                    check("hold_pc", out_pc, last_pc);
                    check("hold_instr", 64'(out_instr), 64'(last_instr));
                end
            end
        end
    end

    // Asserts reset asynchronously mid-cycle, checks the reset outputs, releases on the next cycle.
    task automatic apply_reset(input logic ready_v);
        @(posedge clock);
        #3;
        reset = 1'b0;
        model_restart(RESET_PC);
        #1;
        check("rst_imem_en", 64'(imem_en), 64'd0);
        check("rst_imem_addr", imem_addr, RESET_PC);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_instr", 64'(out_instr), 64'd0);
        check("rst_out_pc", out_pc, 64'd0);
        check("rst_out_pc_link", out_pc_link, 64'd0);
        check("rst_occupancy", 64'(occupancy), 64'd0);
        out_ready = ready_v;
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  n;
        int  v;
        bit  seen;
        reset       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 64'd0;
        out_ready   = 1'b1;
        imem_rdata  = 32'd0;
        model_restart(RESET_PC);

        // Sequential fetch from reset with decode always ready.
        apply_reset(1'b1);
        @(negedge clock);
        check("boot_no_issue", 64'(imem_en), 64'd0);
        n    = 0;
        seen = 0;
        while (!seen && n < 20) begin
            @(posedge clock);
            n++;
            @(negedge clock);
            if (n == 1) begin
                check("c1_issue", 64'(imem_en), 64'd1);
                check("c1_addr", imem_addr, RESET_PC);
            end
            if (out_valid) seen = 1;
        end
        check("first_valid_latency", 64'(n), 64'(FIRST_LAT));
        v = 0;
        repeat (10) begin
            @(negedge clock);
            if (out_valid) v++;
        end
        check("stream_no_gap", 64'(v), 64'd10);

        // Decode stalled: FIFO saturates, fetch holds, head stays at the first word.
        apply_reset(1'b0);
        repeat (10) @(posedge clock);
        @(negedge clock);
        check("stall_occupancy", 64'(occupancy), 64'(DEPTH));
        check("stall_imem_en", 64'(imem_en), 64'd0);
        check("stall_out_valid", 64'(out_valid), 64'd1);
        check("stall_out_pc", out_pc, 64'd0);
        check("stall_out_pc_link", out_pc_link, 64'd4);
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        repeat (20) @(posedge clock);

        // Redirect with three buffered entries and one read in flight.
        apply_reset(1'b0);
        for (int k = 0; k < 20; k++) begin
            @(posedge clock);
            #1;
            if (occupancy == 3'd3) break;
        end
        check("pre_redirect_occupancy", 64'(occupancy), 64'd3);
        set_redirect(64'h1002);
        @(posedge clock);
        #1;
        redirect  = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        check("redir_occupancy", 64'(occupancy), 64'd0);
        check("redir_imem_en", 64'(imem_en), 64'd1);
        check("redir_imem_addr", imem_addr, 64'h1000);
        check("redir_t1_valid", 64'(out_valid), 64'd0);
        @(negedge clock);
        check("redir_t2_valid", 64'(out_valid), 64'(BYP));
        @(negedge clock);
        check("redir_t3_valid", 64'(out_valid), 64'd1);
        repeat (10) @(posedge clock);

        // Redirect colliding with a pop: the head is discarded, the target follows.
        @(posedge clock);
        #1;
        set_redirect(64'h2000);
        @(negedge clock);
        check("collide_out_valid", 64'(out_valid), 64'd1);
        @(posedge clock);
        #1;
        redirect = 1'b0;
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clock);
            if (out_valid) begin
                check("collide_next_pc", out_pc, 64'h2000);
                seen = 1;
            end
        end
        check("collide_next_seen", 64'(seen), 64'd1);
        repeat (5) @(posedge clock);

        // Address wrap at the top of the space.
        @(posedge clock);
        #1;
        set_redirect(64'hFFFF_FFFF_FFFF_FFFE);
        @(posedge clock);
        #1;
        redirect = 1'b0;
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clock);
            if (out_valid) begin
                check("wrap_top_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
                check("wrap_top_link", out_pc_link, 64'd0);
                seen = 1;
            end
        end
        check("wrap_top_seen", 64'(seen), 64'd1);
        @(negedge clock);
        check("wrap_next_valid", 64'(out_valid), 64'd1);
        check("wrap_next_pc", out_pc, 64'd0);
        check("wrap_next_link", out_pc_link, 64'd4);
        repeat (5) @(posedge clock);

        // Reset pulsed mid-stream, fetch restarts at RESET_PC.
        apply_reset(1'b1);
        repeat (15) @(posedge clock);

        // Randomized decode back-pressure and redirects.
        repeat (1500) begin
            @(posedge clock);
            #1;
            out_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 99) < 4) begin
                set_redirect({$urandom(), $urandom()});
            end else begin
                redirect = 1'b0;
            end
        end
        @(posedge clock);
        #1;
        redirect = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
